// File: rtl/rc6_blk_packer.sv
// Packs 32-bit host words into 128-bit RC6 blocks (A,B,C,D order) and queues them for the core.
// Optional byte reversal of each input word when RC6_PKR_BSWAP_EN is defined.
module rc6_blk_packer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       zset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_word,
  input  logic                       in_last,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [WORD_W*NWORDS-1:0]   blk_data,
  output logic                       blk_pad,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                blk_cnt
);

  localparam int BLK_W = WORD_W * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int NB    = WORD_W / 8;

  logic [IDX_W-1:0] r_idx;
  logic [BLK_W-1:0] r_partial;
  logic [BLK_W-1:0] r_mem [DEPTH];
  logic             r_pad_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_next;
  logic [15:0]      r_blk_cnt;

  logic [WORD_W-1:0] w_word;
  logic [BLK_W-1:0]  w_merged;
  logic              w_last_idx;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  genvar gi;

`ifdef RC6_PKR_BSWAP_EN
  for (gi = 0; gi < NB; gi++) begin : g_bswap
    assign w_word[gi*8 +: 8] = in_word[(NB-1-gi)*8 +: 8];
  end
`else
  assign w_word = in_word;
`endif

  // Untouched higher words are still zero, so a short block is already zero-padded here.
  for (gi = 0; gi < NWORDS; gi++) begin : g_merge
    assign w_merged[gi*WORD_W +: WORD_W] =
      (r_idx == IDX_W'(gi)) ? w_word : r_partial[gi*WORD_W +: WORD_W];
  end

  assign in_ready   = ~reset & ~zset & (r_level < LVL_W'(DEPTH));
  assign blk_valid  = (r_level != '0);
  assign w_last_idx = (r_idx == IDX_W'(NWORDS - 1));
  assign w_accept   = in_valid & in_ready;
  assign w_push     = w_accept & (w_last_idx | in_last);
  assign w_pop      = blk_valid & blk_ready & ~zset;

  assign blk_data = r_mem[r_rd_ptr];
  assign blk_pad  = r_pad_mem[r_rd_ptr];
  assign level    = r_level;
  assign blk_cnt  = r_blk_cnt;

  always_comb begin
    w_level_next = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_partial <= '0;
    end else if (zset) begin
      r_idx     <= '0;
      r_partial <= '0;
    end else if (w_push) begin
      r_idx     <= '0;
      r_partial <= '0;
    end else if (w_accept) begin
      r_idx     <= r_idx + IDX_W'(1);
      r_partial <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_blk_cnt <= '0;
    end else if (zset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_blk_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_next;
    end
  end

  // Storage is not cleared by zset; the emptied level already masks stale entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]     <= '0;
        r_pad_mem[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr]     <= w_merged;
      r_pad_mem[r_wr_ptr] <= ~w_last_idx;
    end
  end

endmodule
